// File: rtl/fifo_spi_pkg.sv
// fifo_spi_pkg: shared state encoding and default sizing for the FIFO-fed SPI transmitter.
package fifo_spi_pkg;
    typedef enum logic [2:0] {IDLE, READ, LOAD, SHIFT, GAP} state_t;
    localparam int DEF_WIDTH   = 16;
    localparam int DEF_CLK_DIV = 2;
endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: divides clk down to an idle-low sclk while enabled, with edge strobes for the FSM.
module spi_clk_gen
    import fifo_spi_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    output logic o_sclk,
    output logic o_rise_tick,
    output logic o_fall_tick
);
    localparam int CW = $clog2(CLK_DIV + 1);
    logic [CW-1:0] r_cnt;
    logic          r_sclk;
    logic          w_wrap;
    assign w_wrap      = i_en && (r_cnt == CW'(CLK_DIV - 1));
    assign o_rise_tick = w_wrap && !r_sclk;
    assign o_fall_tick = w_wrap && r_sclk;
    assign o_sclk      = r_sclk;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (!i_en) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else begin
            r_cnt  <= w_wrap ? '0 : r_cnt + 1'b1;
            r_sclk <= w_wrap ? !r_sclk : r_sclk;
        end
    end
endmodule

// File: rtl/fifo_spi_tx.sv
// fifo_spi_tx: drains a 16-bit FIFO and shifts each word out MSB-first as an SPI mode-0 master.
// Define FIFO_SPI_TX_BURST_EN to chain queued words without releasing ss_n between them.
module fifo_spi_tx
    import fifo_spi_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data_out,
    output logic             fifo_rd_en,
    output logic             sclk,
    output logic             mosi,
    output logic             ss_n,
    output logic             busy,
    output logic             frame_done
);
    localparam int BW = $clog2(WIDTH + 1);
    localparam int GW = $clog2(CLK_DIV + 1);
    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [BW-1:0]    r_bits;
    logic [GW-1:0]    r_gap;
    logic             r_last;
    logic             r_frame_done;
    logic             r_burst;
    logic             w_rise;
    logic             w_fall;
    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_en        (r_state == SHIFT),
        .o_sclk      (sclk),
        .o_rise_tick (w_rise),
        .o_fall_tick (w_fall)
    );
    assign fifo_rd_en = (r_state == READ);
    assign busy       = (r_state != IDLE);
    assign mosi       = (r_state == SHIFT) ? r_shift[WIDTH-1] : 1'b0;
    assign ss_n       = !((r_state == SHIFT) || r_burst);
    assign frame_done = r_frame_done;
    // r_last arms on the final rising edge so the matching falling edge ends the word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_bits       <= '0;
            r_gap        <= '0;
            r_last       <= 1'b0;
            r_frame_done <= 1'b0;
            r_burst      <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: r_state <= (enable && !fifo_empty) ? READ : IDLE;
                READ: r_state <= LOAD;
                LOAD: begin
                    r_shift <= fifo_data_out;
                    r_bits  <= BW'(WIDTH);
                    r_last  <= 1'b0;
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    if (w_rise && r_bits == BW'(1))
                        r_last <= 1'b1;
                    if (w_fall) begin
                        r_shift <= {r_shift[WIDTH-2:0], 1'b0};
                        r_bits  <= r_bits - 1'b1;
                    end
                    if (w_fall && r_last) begin
                        r_frame_done <= 1'b1;
                        r_gap        <= '0;
`ifdef FIFO_SPI_TX_BURST_EN
                        r_burst      <= enable && !fifo_empty;
                        r_state      <= (enable && !fifo_empty) ? READ : GAP;
`else
                        r_state      <= GAP;
`endif
                    end
                end
                GAP: begin
                    r_gap   <= r_gap + 1'b1;
                    r_state <= (r_gap == GW'(CLK_DIV - 1)) ? IDLE : GAP;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_spi_tx.sv
// tb_fifo_spi_tx: directed scoreboard bench for fifo_spi_tx with a small FIFO model and SPI monitor.
module tb_fifo_spi_tx;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        fifo_empty;
    logic [15:0] fifo_data_out = '0;
    logic        fifo_rd_en, sclk, mosi, ss_n, busy, frame_done;
    int n_chk = 0, n_fail = 0;
    logic [15:0] fifo_mem [8];
    int wr_ptr = 0, rd_ptr = 0, underflow = 0;
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    int rises = 0, rd_cnt = 0, fd_cnt = 0, ss_low = 0, ss_rise = 0, viol = 0, bitcnt = 0;
    logic [15:0] rx = '0;
    logic prev_sclk = 1'b0, prev_ss = 1'b1, prev_mosi = 1'b0;

    fifo_spi_tx #(.WIDTH(16), .CLK_DIV(2)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data_out(fifo_data_out), .fifo_rd_en(fifo_rd_en), .sclk(sclk),
        .mosi(mosi), .ss_n(ss_n), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (wr_ptr == rd_ptr) underflow++;
            fifo_data_out <= fifo_mem[rd_ptr[2:0]];
            rd_ptr <= rd_ptr + 1;
        end
    end

    // Slave view: sample mosi on each sclk rise, observed half a clk away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            bitcnt = 0;
            prev_sclk = 1'b0;
            prev_ss = 1'b1;
        end else begin
            if (sclk && !prev_sclk) begin
                rx = {rx[14:0], mosi};
                rises++;
                bitcnt++;
                if (bitcnt == 16) begin
                    got_q.push_back(rx);
                    bitcnt = 0;
                end
            end
            if (sclk && prev_sclk && mosi != prev_mosi) viol++;
            if (ss_n && !prev_ss) ss_rise++;
            if (!ss_n) ss_low++;
            if (fifo_rd_en) rd_cnt++;
            if (frame_done) fd_cnt++;
            prev_sclk = sclk;
            prev_ss = ss_n;
        end
        prev_mosi = mosi;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [15:0] w);
        fifo_mem[wr_ptr[2:0]] = w;
        wr_ptr = wr_ptr + 1;
        exp_q.push_back(w);
    endtask

    task automatic wait_fd(input int budget);
        int k = 0;
        while (!frame_done && k < budget) begin
            step();
            k++;
        end
        chk("frame_done_seen", {31'd0, frame_done}, 32'd1);
    endtask

    task automatic compare_words(input int n);
        logic [15:0] e, g;
        chk("word_count", got_q.size(), n);
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            chk("word", {16'd0, g}, {16'd0, e});
        end
    endtask

    initial begin
        int r0, rd0, fd0, sl0, sr0, k, bad;
        step(3);
        chk("rst_ss_n", {31'd0, ss_n}, 32'd1);
        chk("rst_sclk", {31'd0, sclk}, 32'd0);
        chk("rst_mosi", {31'd0, mosi}, 32'd0);
        chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        rst_n = 1'b1;
        step();

        // Single word 16'hA5C3.
        r0 = rises; rd0 = rd_cnt; fd0 = fd_cnt; sl0 = ss_low;
        push(16'hA5C3);
        enable = 1'b1;
        k = 0;
        while (!fifo_rd_en && k < 10) begin step(); k++; end
        chk("rd_en_seen", {31'd0, fifo_rd_en}, 32'd1);
        step();
        chk("rd_en_one_cycle", {31'd0, fifo_rd_en}, 32'd0);
        chk("ss_n_before_shift", {31'd0, ss_n}, 32'd1);
        step();
        chk("ss_n_fall", {31'd0, ss_n}, 32'd0);
        chk("first_mosi", {31'd0, mosi}, 32'd1);
        wait_fd(200);
        chk("gap_ss_n", {31'd0, ss_n}, 32'd1);
        chk("gap_sclk", {31'd0, sclk}, 32'd0);
        chk("gap_mosi", {31'd0, mosi}, 32'd0);
        chk("gap_busy", {31'd0, busy}, 32'd1);
        step();
        chk("gap2_ss_n", {31'd0, ss_n}, 32'd1);
        chk("frame_done_pulse", {31'd0, frame_done}, 32'd0);
        step(10);
        chk("single_rises", rises - r0, 32'd16);
        chk("single_rd", rd_cnt - rd0, 32'd1);
        chk("single_fd", fd_cnt - fd0, 32'd1);
        chk("single_ss_low", ss_low - sl0, 32'd64);
        compare_words(1);

        // Empty FIFO with enable held high.
        rd0 = rd_cnt;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (!ss_n || busy) bad++;
        end
        chk("empty_idle", bad, 32'd0);
        chk("empty_rd", rd_cnt - rd0, 32'd0);

        // Enable dropped during the fourth bit of the first of three words.
        r0 = rises; rd0 = rd_cnt; fd0 = fd_cnt;
        push(16'h1234);
        push(16'hBEEF);
        push(16'h0F0F);
        k = 0;
        while (rises - r0 < 4 && k < 200) begin step(); k++; end
        chk("drop_point", rises - r0, 32'd4);
        enable = 1'b0;
        wait_fd(200);
        step(100);
        chk("drop_rd", rd_cnt - rd0, 32'd1);
        chk("drop_fd", fd_cnt - fd0, 32'd1);
        chk("drop_left", wr_ptr - rd_ptr, 32'd2);
        compare_words(1);

        // Reset after the seventh sclk rise of the next word.
        r0 = rises; rd0 = rd_cnt;
        enable = 1'b1;
        k = 0;
        while (rises - r0 < 7 && k < 200) begin step(); k++; end
        chk("reset_point", rises - r0, 32'd7);
        rst_n = 1'b0;
        #1;
        chk("midrst_ss_n", {31'd0, ss_n}, 32'd1);
        chk("midrst_sclk", {31'd0, sclk}, 32'd0);
        chk("midrst_mosi", {31'd0, mosi}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        void'(exp_q.pop_front());
        step(3);
        rst_n = 1'b1;
        wait_fd(300);
        step(5);
        compare_words(1);
        chk("midrst_rd", rd_cnt - rd0, 32'd2);
        chk("midrst_left", wr_ptr - rd_ptr, 32'd0);

`ifdef FIFO_SPI_TX_BURST_EN
        // Burst of two words under one ss_n assertion.
        enable = 1'b0;
        step(5);
        r0 = rises; fd0 = fd_cnt; sr0 = ss_rise;
        push(16'h0001);
        push(16'h8000);
        enable = 1'b1;
        k = 0;
        while ((fd_cnt - fd0 < 2 || busy) && k < 400) begin step(); k++; end
        step(5);
        chk("burst_rises", rises - r0, 32'd32);
        chk("burst_fd", fd_cnt - fd0, 32'd2);
        chk("burst_ss_rise", ss_rise - sr0, 32'd1);
        compare_words(2);
`endif

        chk("mosi_stable_high", viol, 32'd0);
        chk("underflow", underflow, 32'd0);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
